// File: rtl/dmem_access_ctrl.sv
// Two-port arbiter/sequencer in front of a single-port data memory: round-robin grant,
// read-modify-write sub-word stores, extended sub-word loads. DMEM_ACCESS_FIXED_PRIO_EN = port 0 always wins.
module dmem_access_ctrl #(
  parameter int XLEN = 32,
  parameter int AW   = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [1:0]        i_req_we,
  input  logic [1:0]        i_req_unsigned,
  input  logic [3:0]        i_req_size,
  input  logic [2*XLEN-1:0] i_req_addr,
  input  logic [2*XLEN-1:0] i_req_wdata,
  output logic [1:0]        o_rsp_valid,
  output logic              o_rsp_err,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_mem_r_en,
  output logic              o_mem_w_en,
  output logic [AW-1:0]     o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, RMW_RD, WR} state_e;

  state_e          state_q, state_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic            uns_q, uns_d;
  logic [1:0]      size_q, size_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

  logic            grant, accept, sel_misaligned;
  logic [1:0]      sel_size;
  logic [AW+1:0]   sel_addr;
  logic [XLEN-1:0] sel_wdata;
  logic [4:0]      shamt;
  logic [15:0]     lane;
  logic [XLEN-1:0] load_val, lane_mask, store_word;
  logic            unused_addr_hi;

`ifdef DMEM_ACCESS_FIXED_PRIO_EN
  assign grant = ~i_req_valid[0];
`else
  logic last_q, last_d;
  assign grant = (&i_req_valid) ? ~last_q : i_req_valid[1];
`endif

  // Word index wraps modulo 2^AW, so byte-address bits above AW+1 carry no meaning.
  assign unused_addr_hi = ^{i_req_addr[2*XLEN-1:XLEN+AW+2], i_req_addr[XLEN-1:AW+2]};

  assign accept      = (state_q == IDLE) && (|i_req_valid) && !i_rst;
  assign o_req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign sel_size  = grant ? i_req_size[3:2] : i_req_size[1:0];
  assign sel_addr  = grant ? i_req_addr[XLEN+AW+1:XLEN] : i_req_addr[AW+1:0];
  assign sel_wdata = grant ? i_req_wdata[2*XLEN-1:XLEN] : i_req_wdata[XLEN-1:0];
  assign sel_misaligned = (sel_size == 2'b11) ||
                          (sel_size == 2'b01 && sel_addr[0]) ||
                          (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);

  // Little-endian lane select for loads and lane merge for sub-word stores.
  assign shamt = {addr_q[1:0], 3'b000};
  assign lane  = 16'(i_mem_rdata >> shamt);

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{(XLEN-8){lane[7] & ~uns_q}}, lane[7:0]};
      2'b01:   load_val = {{(XLEN-16){lane[15] & ~uns_q}}, lane[15:0]};
      default: load_val = i_mem_rdata;
    endcase
  end

  assign lane_mask  = ((size_q == 2'b00) ? XLEN'(8'hFF) : XLEN'(16'hFFFF)) << shamt;
  assign store_word = (size_q == 2'b10) ? wdata_q
                    : (word_q & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    uns_d       = uns_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    o_mem_r_en  = 1'b0;
    o_mem_w_en  = 1'b0;
    o_mem_wdata = '0;
`ifndef DMEM_ACCESS_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        port_d  = grant;
        we_d    = i_req_we[grant];
        uns_d   = i_req_unsigned[grant];
        size_d  = sel_size;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
`ifndef DMEM_ACCESS_FIXED_PRIO_EN
        last_d  = grant;
`endif
        if (sel_misaligned) begin
          rsp_valid_d[grant] = 1'b1;
          rsp_err_d          = 1'b1;
        end else if (!i_req_we[grant]) begin
          state_d = RD;
        end else begin
          state_d = (sel_size == 2'b10) ? WR : RMW_RD;
        end
      end
      RD: begin
        o_mem_r_en          = 1'b1;
        rsp_rdata_d         = load_val;
        rsp_valid_d[port_q] = 1'b1;
        state_d             = IDLE;
      end
      RMW_RD: begin
        o_mem_r_en = 1'b1;
        word_d     = i_mem_rdata;
        state_d    = WR;
      end
      WR: begin
        o_mem_w_en          = 1'b1;
        o_mem_wdata         = store_word;
        rsp_valid_d[port_q] = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs read 0 throughout a reset cycle, including an aborted in-flight write.
    if (i_rst) begin
      o_mem_r_en  = 1'b0;
      o_mem_w_en  = 1'b0;
      o_mem_wdata = '0;
    end
  end

  assign o_mem_addr  = i_rst ? '0 : addr_q[AW+1:2];
  assign o_rsp_valid = i_rst ? 2'b00 : rsp_valid_q;
  assign o_rsp_err   = !i_rst && rsp_err_q;
  assign o_rsp_rdata = i_rst ? '0 : rsp_rdata_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifndef DMEM_ACCESS_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifndef DMEM_ACCESS_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random traffic against a byte-array
// reference of the memory; the memory itself is modelled here and driven by the DUT ports.
module tb_dmem_access_ctrl;
  localparam int XLEN  = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef DMEM_ACCESS_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_valid = '0, req_ready, req_we = '0, req_uns = '0;
  logic [3:0]        req_size = '0;
  logic [2*XLEN-1:0] req_addr = '0, req_wdata = '0;
  logic [1:0]        rsp_valid;
  logic              rsp_err, mem_r_en, mem_w_en;
  logic [XLEN-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]     mem_addr;

  logic [31:0]   mem [DEPTH];
  logic [7:0]    gold [4*DEPTH];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0]   poke_data = '0;

  int n_vec = 0, n_err = 0;
  int rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0, both_cnt = 0, overlap_cnt = 0;
  logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [31:0]   last_wr_data = '0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_unsigned(req_uns), .i_req_size(req_size),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
    .o_mem_r_en(mem_r_en), .o_mem_w_en(mem_w_en), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_wdata;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  always @(negedge clk) begin
    if (mem_r_en) begin rd_cnt++; last_rd_addr = mem_addr; end
    if (mem_w_en) begin wr_cnt++; last_wr_addr = mem_addr; last_wr_data = mem_wdata; end
    if (mem_r_en && mem_w_en) both_cnt++;
    if (|rsp_valid) rsp_cnt++;
    if (&rsp_valid) overlap_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] gold_word(input int w);
    return {gold[4*w+3], gold[4*w+2], gold[4*w+1], gold[4*w]};
  endfunction

  task automatic poke(input int w, input logic [31:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = AW'(w); poke_data = d;
    for (int k = 0; k < 4; k++) gold[4*w+k] = 8'(d >> (8*k));
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Reference: memory is a flat byte array; the access is legal iff the address is a
  // multiple of the access size; latency is counted in cycles from the accept edge.
  task automatic model(input logic we, input logic uns, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic err, output logic [31:0] rd);
    int n, base;
    longint unsigned v;
    n    = 1 << sz;
    base = int'((a / 4) % DEPTH) * 4 + int'(a % 4);
    err  = (sz == 2'd3) || (a % n != 0);
    rd   = '0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 0;
      for (int k = 0; k < n; k++) v |= longint'(gold[base+k]) << (8*k);
      if (!uns && n < 4 && v[8*n-1]) v |= ~((64'd1 << (8*n)) - 1);
      rd  = v[31:0];
      lat = 2;
    end else begin
      for (int k = 0; k < n; k++) gold[base+k] = 8'(wd >> (8*k));
      lat = (n == 4) ? 2 : 3;
    end
  endtask

  // Drives one request on port p, waits (bounded) for its accept and response.
  // lat = 0 means no accept or no response arrived within the bound.
  task automatic issue(input int p, input logic we, input logic uns, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic err, output logic [31:0] rd);
    bit got;
    @(posedge clk); #1;
    req_we[p] = we; req_uns[p] = uns;
    if (p == 0) begin req_size[1:0] = sz; req_addr[31:0] = a; req_wdata[31:0] = wd; end
    else begin req_size[3:2] = sz; req_addr[63:32] = a; req_wdata[63:32] = wd; end
    req_valid[p] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = req_ready[p];
    end
    lat = 0; err = 1'b0; rd = '0;
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    if (!got) return;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (rsp_valid[p]) begin lat = i; err = rsp_err; rd = rsp_rdata; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_size = 4'b1010; req_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_vec++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
    n_vec++; if (mem_r_en !== 1'b0 || mem_w_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_mem: got r=%b w=%b addr=%0d wdata=%h want 0", mem_r_en, mem_w_en, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    req_valid = 2'b00; rst = 1'b0;
  endtask

  task automatic init_mem();
    for (int w = 0; w < DEPTH; w++) poke(w, $urandom);
  endtask

  task automatic test_byte_load();
    int lat, elat; logic err, eerr; logic [31:0] rd, erd;
    poke(3, 32'h8899AABB);
    model(1'b0, 1'b0, 2'b00, 32'h0D, 32'h0, elat, eerr, erd);
    issue(0, 1'b0, 1'b0, 2'b00, 32'h0D, 32'h0, lat, err, rd);
    n_vec++; if (lat !== 2 || err !== 1'b0) begin n_err++; $display("FAIL byte_load_0d_lat: got lat=%0d err=%b want 2/0", lat, err); end
    n_vec++; if (rd !== 32'hFFFFFFAA || rd !== erd) begin n_err++; $display("FAIL byte_load_0d_data: got %h want %h", rd, 32'hFFFFFFAA); end
    n_vec++; if (last_rd_addr !== 10'd3) begin n_err++; $display("FAIL byte_load_addr: got %0d want 3", last_rd_addr); end
    issue(1, 1'b0, 1'b0, 2'b00, 32'h0E, 32'h0, lat, err, rd);
    n_vec++; if (lat !== 2 || rd !== 32'hFFFFFF99) begin n_err++; $display("FAIL byte_load_0e: got lat=%0d rd=%h want 2/ffffff99", lat, rd); end
    issue(0, 1'b0, 1'b1, 2'b00, 32'h0E, 32'h0, lat, err, rd);
    n_vec++; if (rd !== 32'h00000099) begin n_err++; $display("FAIL byte_load_uns: got %h want 00000099", rd); end
  endtask

  task automatic test_rmw();
    int lat, elat, r0, w0; logic err, eerr; logic [31:0] rd, erd;
    poke(5, 32'h11223344);
    model(1'b1, 1'b0, 2'b01, 32'h16, 32'hBEEF, elat, eerr, erd);
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1, 1'b1, 1'b0, 2'b01, 32'h16, 32'h0000BEEF, lat, err, rd);
    n_vec++; if (lat !== 3 || err !== 1'b0 || rd !== 32'h0) begin
      n_err++; $display("FAIL rmw_rsp: got lat=%0d err=%b rd=%h want 3/0/0", lat, err, rd); end
    n_vec++; if (last_wr_data !== 32'hBEEF3344 || last_wr_addr !== 10'd5) begin
      n_err++; $display("FAIL rmw_wdata: got %h@%0d want beef3344@5", last_wr_data, last_wr_addr); end
    n_vec++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin
      n_err++; $display("FAIL rmw_ops: got %0d reads %0d writes want 1/1", rd_cnt - r0, wr_cnt - w0); end
    n_vec++; if (mem[5] !== 32'hBEEF3344 || mem[5] !== gold_word(5)) begin
      n_err++; $display("FAIL rmw_mem: got %h want beef3344", mem[5]); end
  endtask

  task automatic test_misaligned();
    int lat, ops; logic err; logic [31:0] rd;
    ops = rd_cnt + wr_cnt;
    issue(0, 1'b0, 1'b0, 2'b10, 32'h102, 32'h0, lat, err, rd);
    n_vec++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
      n_err++; $display("FAIL misaligned_rsp: got lat=%0d err=%b rd=%h want 1/1/0", lat, err, rd); end
    n_vec++; if (rd_cnt + wr_cnt !== ops) begin n_err++; $display("FAIL misaligned_mem: got %0d accesses want 0", rd_cnt + wr_cnt - ops); end
    issue(1, 1'b1, 1'b0, 2'b11, 32'h100, 32'h0, lat, err, rd);
    n_vec++; if (lat !== 1 || err !== 1'b1) begin n_err++; $display("FAIL illegal_size: got lat=%0d err=%b want 1/1", lat, err); end
  endtask

  task automatic test_back_to_back();
    int lat, elat; logic err, eerr; logic [31:0] rd, erd;
    model(1'b1, 1'b0, 2'b10, 32'h40, 32'h12345678, elat, eerr, erd);
    issue(0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h12345678, lat, err, rd);
    n_vec++; if (lat !== 2 || err !== 1'b0) begin n_err++; $display("FAIL b2b_store: got lat=%0d err=%b want 2/0", lat, err); end
    issue(1, 1'b0, 1'b1, 2'b01, 32'h42, 32'h0, lat, err, rd);
    n_vec++; if (rd !== 32'h00001234) begin n_err++; $display("FAIL b2b_load_hi: got %h want 00001234", rd); end
    issue(0, 1'b0, 1'b1, 2'b01, 32'h40, 32'h0, lat, err, rd);
    n_vec++; if (rd !== 32'h00005678) begin n_err++; $display("FAIL b2b_load_lo: got %h want 00005678", rd); end
  endtask

  task automatic test_contention();
    int g[4], cyc[4], ng;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    req_we = 2'b00; req_size = 4'b1010; req_addr = {32'h24, 32'h20}; req_valid = 2'b11;
    ng = 0;
    for (int c = 0; c < 16 && ng < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        n_vec++; if (req_ready !== 2'b01 && req_ready !== 2'b10) begin
          n_err++; $display("FAIL contention_onehot: got %b want one-hot", req_ready); end
        g[ng] = req_ready[1] ? 1 : 0; cyc[ng] = c; ng++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    n_vec++; if (ng !== 4) begin n_err++; $display("FAIL contention_count: got %0d grants want 4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_vec++; if (g[i] !== (FIXED_PRIO ? 0 : i % 2)) begin
        n_err++; $display("FAIL contention_grant%0d: got port %0d want %0d", i, g[i], FIXED_PRIO ? 0 : i % 2); end
      if (i > 0) begin
        n_vec++; if (cyc[i] - cyc[i-1] !== 2) begin
          n_err++; $display("FAIL contention_gap%0d: got %0d cycles want 2", i, cyc[i] - cyc[i-1]); end
      end
    end
  endtask

  task automatic test_reset_mid_rmw();
    int w0, s0; bit got;
    poke(130, 32'h55667788);
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_size[1:0] = 2'b01; req_addr[31:0] = 32'h208; req_wdata[31:0] = 32'hCAFE;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req_ready[0]; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    w0 = wr_cnt; s0 = rsp_cnt;
    @(negedge clk);
    n_vec++; if (mem_r_en !== 1'b1) begin n_err++; $display("FAIL midrmw_rd: got r_en=%b want 1", mem_r_en); end
    rst = 1'b1;
    #1;
    n_vec++; if ({mem_r_en, mem_w_en, req_ready, rsp_valid, rsp_err} !== 7'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      n_err++; $display("FAIL midrmw_outputs: got r=%b w=%b rdy=%b rsp=%b addr=%0d want all 0",
                        mem_r_en, mem_w_en, req_ready, rsp_valid, mem_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    n_vec++; if (wr_cnt !== w0 || rsp_cnt !== s0) begin
      n_err++; $display("FAIL midrmw_dropped: got %0d writes %0d rsps want 0/0", wr_cnt - w0, rsp_cnt - s0); end
    n_vec++; if (mem[130] !== gold_word(130)) begin n_err++; $display("FAIL midrmw_mem: got %h want %h", mem[130], gold_word(130)); end
    #1;
    req_we = 2'b00; req_size = 4'b1010; req_addr = {32'h24, 32'h20}; req_valid = 2'b11;
    @(negedge clk);
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL midrmw_first_grant: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_random();
    int lat, elat, p; logic err, eerr, we, uns; logic [1:0] sz; logic [31:0] a, wd, rd, erd;
    for (int t = 0; t < 300; t++) begin
      p   = int'($urandom_range(1, 0));
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
      a   = $urandom;
      wd  = $urandom;
      if (sz != 2'b11 && $urandom_range(3, 0) != 0) a = a & ~((32'd1 << sz) - 1);
      model(we, uns, sz, a, wd, elat, eerr, erd);
      issue(p, we, uns, sz, a, wd, lat, err, rd);
      n_vec++; if (lat !== elat || err !== eerr || rd !== erd) begin
        n_err++; $display("FAIL random%0d p%0d we%0d sz%0d a=%h: got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                          t, p, we, sz, a, lat, err, rd, elat, eerr, erd); end
    end
  endtask

  task automatic test_final();
    int bad = 0;
    for (int w = 0; w < DEPTH; w++) if (mem[w] !== gold_word(w)) bad++;
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL final_mem: got %0d differing words want 0", bad); end
    n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL rw_exclusive: got %0d cycles with both enables want 0", both_cnt); end
    n_vec++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL rsp_overlap: got %0d overlapping pulses want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_byte_load();
    test_rmw();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_contention();
    test_reset_mid_rmw();
    test_final();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
